// File: rtl/pe_pkg.sv
// Shared types for the PE clock-gate controller: FSM state encoding.
package pe_pkg;

  localparam int unsigned CGS_W = 2;

  typedef enum logic [CGS_W-1:0] {
    ST_ACTIVE    = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_GATED     = 2'd2,
    ST_WAKE      = 2'd3
  } clk_gate_state_t;

endpackage

// File: rtl/pe_clk_gate_ctrl_if.sv
// Ifmap stream, MAC status inputs and gating/status outputs of the clock-gate controller.
interface pe_clk_gate_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STAT_WIDTH = 16
);
  import pe_pkg::*;

  logic                  ifmap_valid;
  logic [DATA_WIDTH-1:0] ifmap_data;
  logic                  ifmap_ready;
  logic                  mac_busy;
  logic                  psum_drain_req;
  logic                  force_on;
  logic                  stat_clr;
  logic                  gate_enable;
  logic                  zero_skip;
  logic [CGS_W-1:0]      gate_state;
  logic [STAT_WIDTH-1:0] gated_cycles;

  modport master (
    output ifmap_valid, ifmap_data, mac_busy, psum_drain_req, force_on, stat_clr,
    input  ifmap_ready, gate_enable, zero_skip, gate_state, gated_cycles
  );

  modport slave (
    input  ifmap_valid, ifmap_data, mac_busy, psum_drain_req, force_on, stat_clr,
    output ifmap_ready, gate_enable, zero_skip, gate_state, gated_cycles
  );

endinterface

// File: rtl/pe_clk_gate_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pe_clk_gate_ctrl.sv
// PE clock-enable controller: zero-skip on the ifmap stream, idle-timeout gating
// and fixed-delay wake-up, with a saturating gated-cycle statistic.
module pe_clk_gate_ctrl
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int IDLE_THRESHOLD = 4,
  parameter int WAKE_CYCLES    = 1,
  parameter int STAT_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               rst,
  pe_clk_gate_ctrl_if.slave  io_if
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_THRESHOLD - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  clk_gate_state_t       r_state, w_state_nxt;
  logic [7:0]            r_idle_cnt, w_idle_nxt;
  logic [3:0]            r_wake_cnt, w_wake_nxt;
  logic                  r_zero_skip;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_is_zero;
  logic                  w_work;
  logic                  w_in_gated;
  logic [STAT_WIDTH-1:0] w_gated_cycles;

  assign w_data    = io_if.ifmap_data;
  assign w_is_zero = (w_data == '0);
  // Zero beats never count as work, so they are absorbed even while gated.
  assign w_work    = (io_if.ifmap_valid && !w_is_zero) || io_if.mac_busy ||
                     io_if.psum_drain_req || io_if.force_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACTIVE;
      r_idle_cnt  <= '0;
      r_wake_cnt  <= '0;
      r_zero_skip <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_wake_cnt  <= w_wake_nxt;
      r_zero_skip <= io_if.ifmap_valid && w_is_zero;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wake_nxt  = r_wake_cnt;
    unique case (r_state)
      ST_ACTIVE: begin
        if (!w_work) begin
          w_idle_nxt  = 8'd1;
          w_state_nxt = (IDLE_THRESHOLD == 1) ? ST_GATED : ST_IDLE_WAIT;
        end
      end
      ST_IDLE_WAIT: begin
        if (w_work) begin
          w_state_nxt = ST_ACTIVE;
          w_idle_nxt  = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = ST_GATED;
        end else begin
          w_idle_nxt  = r_idle_cnt + 8'd1;
        end
      end
      ST_GATED: begin
        if (w_work) begin
          w_state_nxt = ST_WAKE;
          w_wake_nxt  = '0;
        end
      end
      ST_WAKE: begin
        w_wake_nxt = r_wake_cnt + 4'd1;
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: w_state_nxt = ST_ACTIVE;
    endcase
  end

  assign w_in_gated = (r_state == ST_GATED);

  sat_counter #(.WIDTH(STAT_WIDTH)) u_gated_stat (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_in_gated),
    .i_clr   (io_if.stat_clr),
    .o_count (w_gated_cycles)
  );

  // Decoded from the state register only, so it is stable while the gating latch is open.
  assign io_if.gate_enable  = !w_in_gated;
  assign io_if.ifmap_ready  = w_is_zero || (r_state == ST_ACTIVE) || (r_state == ST_IDLE_WAIT);
  assign io_if.zero_skip    = r_zero_skip;
  assign io_if.gate_state   = r_state;
  assign io_if.gated_cycles = w_gated_cycles;

endmodule

// File: tb/tb_pe_clk_gate_ctrl.sv
// Scoreboard bench for pe_clk_gate_ctrl: two configurations driven by the same
// stimulus, compared every cycle against a timing-rule reference model.
module tb_pe_clk_gate_ctrl;

  localparam int M_RUN  = 0;
  localparam int M_GATE = 1;
  localparam int M_WAKE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_valid = 1'b0;
  logic [15:0] c_data  = '0;
  logic        c_busy  = 1'b0;
  logic        c_drain = 1'b0;
  logic        c_force = 1'b0;
  logic        c_clr   = 1'b0;

  pe_clk_gate_ctrl_if #(.DATA_WIDTH(16), .STAT_WIDTH(16)) if_a ();
  pe_clk_gate_ctrl_if #(.DATA_WIDTH(16), .STAT_WIDTH(4))  if_b ();

  assign if_a.ifmap_valid = c_valid;    assign if_b.ifmap_valid = c_valid;
  assign if_a.ifmap_data = c_data;      assign if_b.ifmap_data = c_data;
  assign if_a.mac_busy = c_busy;        assign if_b.mac_busy = c_busy;
  assign if_a.psum_drain_req = c_drain; assign if_b.psum_drain_req = c_drain;
  assign if_a.force_on = c_force;       assign if_b.force_on = c_force;
  assign if_a.stat_clr = c_clr;         assign if_b.stat_clr = c_clr;

  pe_clk_gate_ctrl #(.DATA_WIDTH(16), .IDLE_THRESHOLD(4), .WAKE_CYCLES(1), .STAT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .io_if(if_a.slave));
  pe_clk_gate_ctrl #(.DATA_WIDTH(16), .IDLE_THRESHOLD(1), .WAKE_CYCLES(3), .STAT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .io_if(if_b.slave));

  // Reference model: cycles idle since last work, remaining wake cycles, gated-cycle count.
  int th[2]   = '{4, 1};
  int wc[2]   = '{1, 3};
  int cmax[2] = '{65535, 15};
  int m_mode[2], m_idle[2], m_wleft[2], m_cnt[2];
  bit m_zs;

  typedef struct {
    int st_a; int st_b; int cnt_a; int cnt_b;
    bit rdy_a; bit rdy_b; bit zs;
  } exp_t;
  exp_t sbq[$];

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_RUN; m_idle[k] = 0; m_wleft[k] = 0; m_cnt[k] = 0;
    end
    m_zs = 1'b0;
  endfunction

  function automatic int exp_state(input int k);
    if (m_mode[k] == M_GATE) return 2;
    if (m_mode[k] == M_WAKE) return 3;
    return (m_idle[k] == 0) ? 0 : 1;
  endfunction

  function automatic bit exp_ready(input int k, input logic [15:0] d);
    return (d == 16'd0) || (m_mode[k] == M_RUN);
  endfunction

  function automatic void model_edge(input int k, input bit work, input bit clr);
    bit was_gated = (m_mode[k] == M_GATE);
    case (m_mode[k])
      M_RUN: begin
        if (work) m_idle[k] = 0;
        else begin
          m_idle[k]++;
          if (m_idle[k] >= th[k]) m_mode[k] = M_GATE;
        end
      end
      M_GATE: if (work) begin m_mode[k] = M_WAKE; m_wleft[k] = wc[k]; end
      default: begin
        m_wleft[k]--;
        if (m_wleft[k] == 0) begin m_mode[k] = M_RUN; m_idle[k] = 0; end
      end
    endcase
    if (clr) m_cnt[k] = 0;
    else if (was_gated && m_cnt[k] < cmax[k]) m_cnt[k]++;
  endfunction

  // One clock: advance the model over the edge, then drive the next cycle's inputs.
  // A nonzero beat not accepted by the 4-cycle configuration is held stable.
  task automatic step(input bit v, input logic [15:0] d, input bit busy,
                      input bit drain, input bit frc, input bit clr);
    bit   work, hold;
    exp_t e;
    @(posedge clk);
    #1;
    work = (c_valid && c_data != 16'd0) || c_busy || c_drain || c_force;
    hold = c_valid && !exp_ready(0, c_data);
    m_zs = c_valid && (c_data == 16'd0);
    for (int k = 0; k < 2; k++) model_edge(k, work, c_clr);
    if (!hold) begin c_valid = v; c_data = d; end
    c_busy = busy; c_drain = drain; c_force = frc; c_clr = clr;
    e.st_a = exp_state(0); e.st_b = exp_state(1);
    e.cnt_a = m_cnt[0];    e.cnt_b = m_cnt[1];
    e.rdy_a = exp_ready(0, c_data); e.rdy_b = exp_ready(1, c_data);
    e.zs = m_zs;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'd0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("a_state", int'(if_a.gate_state), e.st_a);
        chk("a_gate_en", int'(if_a.gate_enable), int'(e.st_a != 2));
        chk("a_ready", int'(if_a.ifmap_ready), int'(e.rdy_a));
        chk("a_zero_skip", int'(if_a.zero_skip), int'(e.zs));
        chk("a_gated_cycles", int'(if_a.gated_cycles), e.cnt_a);
        chk("b_state", int'(if_b.gate_state), e.st_b);
        chk("b_gate_en", int'(if_b.gate_enable), int'(e.st_b != 2));
        chk("b_ready", int'(if_b.ifmap_ready), int'(e.rdy_b));
        chk("b_zero_skip", int'(if_b.zero_skip), int'(e.zs));
        chk("b_gated_cycles", int'(if_b.gated_cycles), e.cnt_b);
      end
    end
  end

  initial begin : driver
    bit          quiet;
    logic [15:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gate_en", int'(if_a.gate_enable), 1);
    chk("rst_a_state", int'(if_a.gate_state), 0);
    chk("rst_a_gated_cycles", int'(if_a.gated_cycles), 0);
    chk("rst_a_zero_skip", int'(if_a.zero_skip), 0);
    chk("rst_b_gated_cycles", int'(if_b.gated_cycles), 0);
    rst = 1'b0;

    idle(14);
    step(1, 16'h0005, 0, 0, 0, 0);
    idle(4);
    idle(6);
    for (int i = 0; i < 8; i++) step(1, 16'h0000, 0, 0, 0, 0);
    idle(2);
    repeat (3) step(0, 16'd0, 1, 0, 0, 0);
    idle(3);
    step(0, 16'd0, 1, 0, 0, 0);
    idle(2);
    step(1, 16'h0000, 1, 0, 0, 0);
    step(0, 16'd0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 16'd0, 0, 0, 1, 0);
    idle(25);
    step(0, 16'd0, 0, 0, 0, 1);
    idle(3);

    @(negedge clk);
    #1;
    chk("pre_rst_a_state", int'(if_a.gate_state), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_a_gate_en", int'(if_a.gate_enable), 1);
    chk("async_rst_a_state", int'(if_a.gate_state), 0);
    chk("async_rst_b_gate_en", int'(if_b.gate_enable), 1);
    c_valid = 1'b0; c_data = '0; c_busy = 1'b0; c_drain = 1'b0; c_force = 1'b0; c_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 50) % 2) == 1;
      d = 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 9) < 3) d = 16'd0;
      if (quiet) begin
        if ($urandom_range(0, 30) == 0) step(1, d, 0, 0, 0, 0);
        else step($urandom_range(0, 3) == 0, 16'd0, 0, 0, 0, $urandom_range(0, 40) == 0);
      end else begin
        step($urandom_range(0, 1) == 1, d, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 32) == 0);
      end
    end
    idle(4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
